fsm_det_window_counter: RTL and testbench
=========================================

// Module: fsm_det_window_counter
// PURPOSE
//  - Downstream consumer of the serial sequence-detector output y (one bit per clk).
//  - Counts detections over fixed windows of WINDOW clocks and publishes each window's total.
//  - Raises an alarm when a window's total reaches THRESH.
//  - Feeds status/monitor logic that cannot watch single-cycle y pulses directly.
// PARAMETERS
//  WINDOW  16  window length in clk cycles (>=2)
//  CNT_W   5   width of detection counters; counts saturate at 2**CNT_W-1
//  THRESH  4   alarm threshold, compared as count_out >= THRESH
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  en          in   1      run enable; low = window paused, y ignored
//  clr         in   1      synchronous restart of current window
//  y           in   1      detector output, sampled every clk
//  live_count  out  CNT_W  running count of current window
//  count_out   out  CNT_W  total of last completed window
//  count_vld   out  1      one-cycle pulse when count_out updates
//  alarm       out  1      registered (count_out >= THRESH), held until next window close
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, win_cnt=0.
//    live_count=0, count_out=0, count_vld=0, alarm=0. Takes effect immediately, mid-window included.
//  - States:
//    IDLE: entered from reset; -> RUN when en=1 (that cycle already counts).
//    RUN: -> IDLE when en=0. win_cnt and live_count hold; they are not cleared.
//  - RUN, each clk:
//    win_cnt increments.
//    event=1 adds 1 to live_count, saturating at 2**CNT_W-1 (never wraps).
//  - Window close: in RUN with win_cnt==WINDOW-1, on the same edge:
//    count_out <= live_count + event (saturated); the closing cycle's event is included.
//    count_vld <= 1; alarm <= (new count_out >= THRESH); win_cnt <= 0; live_count <= 0.
//  - count_vld is high exactly one cycle per close; latency from the last window sample to count_vld is 1 clk.
//  - clr=1 (any state): win_cnt <= 0, live_count <= 0, and y in that cycle is discarded.
//    count_out, alarm and state are unchanged; no count_vld pulse.
//    clr has priority over a coincident window close (the close is suppressed).
//  - event: y sampled at the clk edge (level mode).
// CONFIGURATION
//  - Macro FSM_DET_EDGE_EN:
//    defined: event = y & ~y_q, where y_q is y registered in RUN and cleared by rst/clr.
//      A run of consecutive y highs counts once.
//    undefined: event = y; every high cycle counts. No y_q register exists.
// STRUCTURE
//  - Package fsm_det_pkg:
//    state typedef {IDLE, RUN}; default constants for WINDOW/CNT_W/THRESH.
//    Saturating-increment function sat_inc(value, width).
//  - Sub-module fsm_det_win_timer:
//    holds win_cnt, inputs run/clr; outputs last_cycle = (win_cnt==WINDOW-1).
//  - Top module holds the FSM, counters and output registers.
// TESTING  (WINDOW=8, CNT_W=4, THRESH=3 unless stated)
//  1. rst=1 then release; en=0; y=1 for 10 clk
//     -> live_count=0, count_vld never pulses, all outputs 0.
//  2. en=1; y=1 on cycles 0,2,4 of window
//     -> at close: count_out=3, count_vld pulses once, alarm=1.
//     Next window y=0 -> count_out=0, alarm=0.
//  3. en=1; y=1 for cycles 0..2 contiguous
//     -> count_out=3 without FSM_DET_EDGE_EN; count_out=1 with it (alarm=0).
//  4. CNT_W=3, WINDOW=16; y=1 all 16 cycles
//     -> live_count sticks at 7, count_out=7, no wrap.
//  5. en=1; y=1 on cycle 7 only (last cycle) -> count_out=1.
//     Repeat with clr=1 on cycle 7 -> no count_vld; new window starts; count_out keeps prior value.
//  6. rst pulsed mid-window (cycle 4) with live_count=2
//     -> all outputs 0 immediately; after release, state=IDLE until en=1.

Source files
------------

// File: rtl/fsm_det_pkg.sv
// Shared types and helpers for the detection window counter.
// Holds the two-state FSM encoding, default parameter values and the
// saturating increment used by the detection counters.
package fsm_det_pkg;

  // FSM encoding kept as plain constants so older tools and checkers can bind to it.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Default configuration.
  localparam int WINDOW_DEF = 16;
  localparam int CNT_W_DEF  = 5;
  localparam int THRESH_DEF = 4;

  // Add one to value, sticking at 2**width-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    if (width >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (value >= max_v) begin
      return max_v;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/fsm_det_win_timer.sv
// Window position timer.
// Counts clocks while run is high, restarts on clr, and flags the final
// cycle of each WINDOW-long window so the top can close it on that edge.
module fsm_det_win_timer
  import fsm_det_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic last_cycle
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] LAST_POS = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] win_cnt_q;
  logic [WIN_W-1:0] win_cnt_d;

  assign last_cycle = (win_cnt_q == LAST_POS);

  // Next window position: restart on clr or after the last cycle, hold while paused.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (clr) begin
      win_cnt_d = '0;
    end else if (run) begin
      if (last_cycle) begin
        win_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  // Window position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: rtl/fsm_det_window_counter.sv
// Detection window counter.
// Counts detector pulses (y) over fixed windows of WINDOW clocks, publishes
// each window's saturated total on count_out with a one-cycle count_vld
// pulse, and raises alarm when that total reaches THRESH.
// Optional feature: define FSM_DET_EDGE_EN to count rising edges of y
// instead of every high cycle.
//
// Interface note: there is no ready/back-pressure. count_vld is a
// single-cycle strobe marking the cycle in which count_out and alarm carry a
// freshly closed window; consumers must take it that cycle. count_out and
// alarm then hold until the next close.
module fsm_det_window_counter
  import fsm_det_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             y,
  output logic [CNT_W-1:0] live_count,
  output logic [CNT_W-1:0] count_out,
  output logic             count_vld,
  output logic             alarm,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] live_count_q, live_count_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_vld_q, count_vld_d;
  logic             alarm_q, alarm_d;

  logic             last_cycle;
  logic             event_w;
  logic [CNT_W-1:0] live_inc;

  // Window position tracking; advances on every enabled cycle.
  fsm_det_win_timer #(
    .WINDOW (WINDOW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (en),
    .clr        (clr),
    .last_cycle (last_cycle)
  );

`ifdef FSM_DET_EDGE_EN
  logic y_q, y_d;

  // Previous y, tracked only while counting; clr forgets history so a
  // y that is already high after a restart counts as a fresh edge.
  always_comb begin
    y_d = y_q;
    if (clr) begin
      y_d = 1'b0;
    end else if (en) begin
      y_d = y;
    end
  end

  // Previous-y register for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign event_w = y & ~y_q;
`else
  assign event_w = y;
`endif

  // Count including this cycle's event, stuck at the top value.
  assign live_inc = event_w ? CNT_W'(sat_inc(32'(live_count_q), CNT_W)) : live_count_q;

  // FSM: en alone decides the state; the enabling cycle itself is counted
  // below, so IDLE->RUN has no dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and output datapath. clr wins over a coincident close, and a
  // paused window keeps its count.
  always_comb begin
    live_count_d = live_count_q;
    count_out_d  = count_out_q;
    alarm_d      = alarm_q;
    count_vld_d  = 1'b0;
    if (clr) begin
      live_count_d = '0;
    end else if (en) begin
      if (last_cycle) begin
        live_count_d = '0;
        count_out_d  = live_inc;
        alarm_d      = (32'(live_inc) >= 32'(THRESH));
        count_vld_d  = 1'b1;
      end else begin
        live_count_d = live_inc;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      live_count_q <= '0;
      count_out_q  <= '0;
      count_vld_q  <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      live_count_q <= live_count_d;
      count_out_q  <= count_out_d;
      count_vld_q  <= count_vld_d;
      alarm_q      <= alarm_d;
    end
  end

  assign live_count = live_count_q;
  assign count_out  = count_out_q;
  assign count_vld  = count_vld_q;
  assign alarm      = alarm_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fsm_det_window_counter.sv
// Bench for fsm_det_window_counter.
// Two instances share one input stream: A (WINDOW=8, CNT_W=4, THRESH=3) and
// B (WINDOW=16, CNT_W=3, THRESH=3) for the saturation case. A reference
// model tracks window position and raw hit counts as integers and clamps
// when publishing.
module tb_fsm_det_window_counter;
  import fsm_det_pkg::*;

  logic clk, rst, en, clr, y;
  logic [3:0] live_a, out_a;
  logic       vld_a, alarm_a;
  state_t     st_a;
  logic [2:0] live_b, out_b;
  logic       vld_b, alarm_b;
  state_t     st_b;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fsm_det_window_counter #(.WINDOW(8), .CNT_W(4), .THRESH(3)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y(y),
    .live_count(live_a), .count_out(out_a), .count_vld(vld_a),
    .alarm(alarm_a), .state_dbg(st_a)
  );

  fsm_det_window_counter #(.WINDOW(16), .CNT_W(3), .THRESH(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y(y),
    .live_count(live_b), .count_out(out_b), .count_vld(vld_b),
    .alarm(alarm_b), .state_dbg(st_b)
  );

  // ---------------- reference model ----------------
  int p_win[2] = '{8, 16};
  int p_max[2] = '{15, 7};
  int p_thr[2] = '{3, 3};
  int m_pos[2], m_hits[2], m_out[2], m_vld[2], m_alarm[2], m_prev[2];
  int m_running;

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_hits[i] = 0; m_out[i] = 0;
      m_vld[i] = 0; m_alarm[i] = 0; m_prev[i] = 0;
    end
    m_running = 0;
  endtask

  task automatic model_step(input int e, input int c, input int yy);
    int ev;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0;
      if (c != 0) begin
        m_pos[i] = 0; m_hits[i] = 0; m_prev[i] = 0;
      end else if (e != 0) begin
`ifdef FSM_DET_EDGE_EN
        ev = (yy != 0 && m_prev[i] == 0) ? 1 : 0;
`else
        ev = yy;
`endif
        m_prev[i] = yy;
        m_hits[i] += ev;
        if (m_pos[i] == p_win[i] - 1) begin
          m_out[i]   = clamp(m_hits[i], p_max[i]);
          m_alarm[i] = (m_out[i] >= p_thr[i]) ? 1 : 0;
          m_vld[i]   = 1;
          m_pos[i]   = 0;
          m_hits[i]  = 0;
        end else begin
          m_pos[i]++;
        end
      end
    end
    m_running = e;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a_live",  int'(live_a),  clamp(m_hits[0], p_max[0]));
    chk("a_out",   int'(out_a),   m_out[0]);
    chk("a_vld",   int'(vld_a),   m_vld[0]);
    chk("a_alarm", int'(alarm_a), m_alarm[0]);
    chk("a_state", int'(st_a),    m_running);
    chk("b_live",  int'(live_b),  clamp(m_hits[1], p_max[1]));
    chk("b_out",   int'(out_b),   m_out[1]);
    chk("b_vld",   int'(vld_b),   m_vld[1]);
    chk("b_alarm", int'(alarm_b), m_alarm[1]);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input int e, input int c, input int yy);
    en  = 1'(e);
    clr = 1'(c);
    y   = 1'(yy);
    @(posedge clk);
    model_step(e, c, yy);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; clr = 1'b0; y = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model();
    rst = 1'b0;
  endtask

  // ---------------- vector table (window of y at 0,2,4 then an empty window) ----------------
  typedef struct {
    int en; int clr; int y;
    int live; int out; int vld; int alarm;
  } vec_t;

  vec_t tbl[16];
  int t_live[16]  = '{1,1,2,2,3,3,3,0, 0,0,0,0,0,0,0,0};
  int t_out[16]   = '{0,0,0,0,0,0,0,3, 3,3,3,3,3,3,3,0};
  int t_vld[16]   = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1};
  int t_alarm[16] = '{0,0,0,0,0,0,0,1, 1,1,1,1,1,1,1,0};

`ifdef FSM_DET_EDGE_EN
  localparam int EXP_RUN3  = 1;
  localparam int EXP_SAT_B = 1;
`else
  localparam int EXP_RUN3  = 3;
  localparam int EXP_SAT_B = 7;
`endif

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[k] = '{en: 1, clr: 0, y: ((k == 0 || k == 2 || k == 4) ? 1 : 0),
                 live: t_live[k], out: t_out[k], vld: t_vld[k], alarm: t_alarm[k]};
    end

    // Test 1: reset, then en=0 with y high: nothing counts.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1);
      chk("t1_live", int'(live_a), 0);
      chk("t1_vld",  int'(vld_a),  0);
    end

    // Test 2: table-driven windows.
    for (int k = 0; k < 16; k++) begin
      cyc(tbl[k].en, tbl[k].clr, tbl[k].y);
      chk("tbl_live",  int'(live_a),  tbl[k].live);
      chk("tbl_out",   int'(out_a),   tbl[k].out);
      chk("tbl_vld",   int'(vld_a),   tbl[k].vld);
      chk("tbl_alarm", int'(alarm_a), tbl[k].alarm);
    end

    // Test 3: contiguous run of three highs.
    for (int k = 0; k < 8; k++) cyc(1, 0, (k < 3) ? 1 : 0);
    chk("t3_out",   int'(out_a),   EXP_RUN3);
    chk("t3_vld",   int'(vld_a),   1);
    chk("t3_alarm", int'(alarm_a), (EXP_RUN3 >= 3) ? 1 : 0);

    // Test 4: saturation on B (restart windows first so B is aligned).
    cyc(1, 1, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 0, 1);
      if (k == 14) chk("t4_live_b", int'(live_b), EXP_SAT_B);
    end
    chk("t4_out_b", int'(out_b), EXP_SAT_B);
    chk("t4_vld_b", int'(vld_b), 1);

    // Test 5: event on the closing cycle is included.
    for (int k = 0; k < 8; k++) cyc(1, 0, (k == 7) ? 1 : 0);
    chk("t5_out", int'(out_a), 1);
    chk("t5_vld", int'(vld_a), 1);
    // Same again, but clr on the closing cycle suppresses the close.
    for (int k = 0; k < 8; k++) cyc(1, (k == 7) ? 1 : 0, (k == 7) ? 1 : 0);
    chk("t5_clr_vld",  int'(vld_a),  0);
    chk("t5_clr_out",  int'(out_a),  1);
    chk("t5_clr_live", int'(live_a), 0);
    for (int k = 0; k < 8; k++) cyc(1, 0, (k == 0) ? 1 : 0);
    chk("t5_next_out", int'(out_a), 1);

    // Test 6: async reset mid-window with live_count=2.
    for (int k = 0; k < 4; k++) cyc(1, 0, (k == 0 || k == 2) ? 1 : 0);
    chk("t6_pre_live", int'(live_a), 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_live",  int'(live_a),  0);
    chk("t6_out",   int'(out_a),   0);
    chk("t6_alarm", int'(alarm_a), 0);
    chk("t6_state", int'(st_a),    int'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1);
      chk("t6_idle", int'(st_a), int'(IDLE));
    end
    cyc(1, 0, 0);
    chk("t6_run", int'(st_a), int'(RUN));

    // Randomized stream against the model.
    for (int k = 0; k < 600; k++) begin
      cyc((($urandom_range(0, 9) != 0) ? 1 : 0),
          (($urandom_range(0, 24) == 0) ? 1 : 0),
          int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
